// File: rtl/sram_dp_if.sv
// Request/response bundle for both ports of the sram_dp dual-port memory model.
interface sram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  ready_o;

    logic                  a_req_i;
    logic                  a_we_i;
    logic [ADDR_WIDTH-1:0] a_addr_i;
    logic [DATA_WIDTH-1:0] a_wdata_i;
    logic [BE_WIDTH-1:0]   a_be_i;
    logic [DATA_WIDTH-1:0] a_rdata_o;
    logic                  a_rvalid_o;

    logic                  b_req_i;
    logic                  b_we_i;
    logic [ADDR_WIDTH-1:0] b_addr_i;
    logic [DATA_WIDTH-1:0] b_wdata_i;
    logic [BE_WIDTH-1:0]   b_be_i;
    logic [DATA_WIDTH-1:0] b_rdata_o;
    logic                  b_rvalid_o;

    modport master (
        input  ready_o, a_rdata_o, a_rvalid_o, b_rdata_o, b_rvalid_o,
        output a_req_i, a_we_i, a_addr_i, a_wdata_i, a_be_i,
        output b_req_i, b_we_i, b_addr_i, b_wdata_i, b_be_i
    );

    modport slave (
        output ready_o, a_rdata_o, a_rvalid_o, b_rdata_o, b_rvalid_o,
        input  a_req_i, a_we_i, a_addr_i, a_wdata_i, a_be_i,
        input  b_req_i, b_we_i, b_addr_i, b_wdata_i, b_be_i
    );
endinterface

// File: rtl/sram_dp.sv
// True dual-port SRAM model with byte enables and a per-port read-latency pipeline.
// Optional macro SRAM_DP_INIT_ZERO_EN zero-fills the array after reset before accepting requests.
module sram_dp #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 16384,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic     clk_i,
    input  logic     rst_i,
    sram_dp_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int NP         = 2;

    logic [DATA_WIDTH-1:0] ram [NUM_WORDS];

    logic                  ready;
    logic                  req      [NP];
    logic                  we       [NP];
    logic [ADDR_WIDTH-1:0] addr     [NP];
    logic [DATA_WIDTH-1:0] wdata    [NP];
    logic [BE_WIDTH-1:0]   be       [NP];
    logic                  in_range [NP];
    logic                  rd_acc   [NP];
    logic                  wr_acc   [NP];
    logic [DATA_WIDTH-1:0] rd_word  [NP];
    logic                  rvalid   [NP];
    logic [DATA_WIDTH-1:0] rdata    [NP];

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] upd,
        input logic [BE_WIDTH-1:0]   en
    );
        logic [DATA_WIDTH-1:0] r;
        r = base;
        for (int k = 0; k < BE_WIDTH; k++)
            if (en[k]) r[8*k +: 8] = upd[8*k +: 8];
        return r;
    endfunction

    assign req[0]   = bus.a_req_i;
    assign we[0]    = bus.a_we_i;
    assign addr[0]  = bus.a_addr_i;
    assign wdata[0] = bus.a_wdata_i;
    assign be[0]    = bus.a_be_i;
    assign req[1]   = bus.b_req_i;
    assign we[1]    = bus.b_we_i;
    assign addr[1]  = bus.b_addr_i;
    assign wdata[1] = bus.b_wdata_i;
    assign be[1]    = bus.b_be_i;

`ifdef SRAM_DP_INIT_ZERO_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_wr;

    assign init_wr = (state == ST_INIT) && !rst_i;
    assign ready   = (state == ST_RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            if (init_cnt == ADDR_WIDTH'(NUM_WORDS - 1)) state <= ST_RUN;
            else                                        init_cnt <= init_cnt + 1'b1;
        end
    end
`else
    assign ready = 1'b1;
`endif

    // Reset wins over any request presented on the same edge.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            in_range[p] = int'(addr[p]) < NUM_WORDS;
            rd_acc[p]   = req[p] && !we[p] && ready && !rst_i;
            wr_acc[p]   = req[p] && we[p] && ready && !rst_i && in_range[p];
        end
    end

    // Cross-port collision: write-first readers see the other port's enabled bytes.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            rd_word[p] = '0;
            if (in_range[p]) begin
                rd_word[p] = ram[addr[p]];
                if (RDW_MODE == 1 && wr_acc[NP-1-p] && addr[NP-1-p] == addr[p])
                    rd_word[p] = merge_bytes(rd_word[p], wdata[NP-1-p], be[NP-1-p]);
            end else begin
`ifdef SYNTHESIS
                rd_word[p] = '0;
`else
                rd_word[p] = 'x;
`endif
            end
        end
    end

    // Port B is applied first so port A overrides bytes both ports enable.
    always_ff @(posedge clk_i) begin
`ifdef SRAM_DP_INIT_ZERO_EN
        if (init_wr) ram[init_cnt] <= '0;
`endif
        for (int k = 0; k < BE_WIDTH; k++) begin
            if (wr_acc[1] && be[1][k]) ram[addr[1]][8*k +: 8] <= wdata[1][8*k +: 8];
            if (wr_acc[0] && be[0][k]) ram[addr[0]][8*k +: 8] <= wdata[0][8*k +: 8];
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_port
        logic [READ_LATENCY-1:0]                 vld_p;
        logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] data_p;
        logic [READ_LATENCY:0]                   vld_chain;
        logic [READ_LATENCY:0][DATA_WIDTH-1:0]   data_chain;

        assign vld_chain  = {vld_p, rd_acc[p]};
        assign data_chain = {data_p, rd_word[p]};

        always_ff @(posedge clk_i) begin
            if (rst_i) vld_p <= '0;
            else       vld_p <= vld_chain[READ_LATENCY-1:0];
        end

        // Output stage only loads on a valid read, so rdata holds between pulses.
        always_ff @(posedge clk_i) begin
            for (int s = 0; s < READ_LATENCY - 1; s++) data_p[s] <= data_chain[s];
            if (rst_i)                            data_p[READ_LATENCY-1] <= '0;
            else if (vld_chain[READ_LATENCY-1])   data_p[READ_LATENCY-1] <= data_chain[READ_LATENCY-1];
        end

        assign rvalid[p] = vld_p[READ_LATENCY-1];
        assign rdata[p]  = data_p[READ_LATENCY-1];
    end

    assign bus.ready_o    = ready;
    assign bus.a_rvalid_o = rvalid[0];
    assign bus.a_rdata_o  = rdata[0];
    assign bus.b_rvalid_o = rvalid[1];
    assign bus.b_rdata_o  = rdata[1];
endmodule
